// File: rtl/stq_fwd_age_select.sv
// Registered, multi-port store-queue forwarding age selector: youngest matching store older than each load.
// Optional STQ_HEAD_MASK_EN restricts candidates to the circular window stq_head .. youngest-1.
module stq_fwd_age_select #(
  parameter int NUM_STQ   = 32,
  parameter int IDX_W     = $clog2(NUM_STQ),
  parameter int NUM_PORTS = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [IDX_W-1:0]               stq_head,
  input  logic [NUM_PORTS-1:0]           req_valid,
  output logic [NUM_PORTS-1:0]           req_ready,
  input  logic [NUM_PORTS*NUM_STQ-1:0]   req_matches,
  input  logic [NUM_PORTS*IDX_W-1:0]     req_youngest,
  output logic [NUM_PORTS-1:0]           resp_valid,
  input  logic [NUM_PORTS-1:0]           resp_ready,
  output logic [NUM_PORTS-1:0]           resp_hit,
  output logic [NUM_PORTS*IDX_W-1:0]     resp_idx,
  output logic [NUM_PORTS-1:0]           resp_multi
);

  localparam logic [IDX_W:0] NUM_STQ_L = (IDX_W+1)'(NUM_STQ);

`ifndef STQ_HEAD_MASK_EN
  logic unused_head;
  assign unused_head = ^stq_head;
`endif

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [IDX_W-1:0]   yng;
    logic [NUM_STQ-1:0] m;
    logic               s1_found;
    logic               any_found;
    logic               many;
    logic [IDX_W-1:0]   s1_idx;
    logic [IDX_W-1:0]   s2_idx;
    logic               sel_hit;
    logic [IDX_W-1:0]   sel_idx;
    logic               accept;
    logic               valid_q;
    logic               hit_q;
    logic [IDX_W-1:0]   idx_q;
    logic               multi_q;

    assign yng = req_youngest[p*IDX_W +: IDX_W];

    always_comb begin
      m = req_matches[p*NUM_STQ +: NUM_STQ];
`ifdef STQ_HEAD_MASK_EN
      // head == youngest yields an empty window: both comparisons below fail for every k
      for (int k = 0; k < NUM_STQ; k++) begin
        if (int'(stq_head) <= int'(yng)) begin
          if (!(k >= int'(stq_head) && k < int'(yng))) m[k] = 1'b0;
        end else begin
          if (!(k >= int'(stq_head) || k < int'(yng))) m[k] = 1'b0;
        end
      end
`endif
    end

    // Ascending scan: the last hit seen is the highest index in each stage
    always_comb begin
      s1_found  = 1'b0;
      any_found = 1'b0;
      many      = 1'b0;
      s1_idx    = '0;
      s2_idx    = '0;
      for (int k = 0; k < NUM_STQ; k++) begin
        if (m[k]) begin
          many      = many | any_found;
          any_found = 1'b1;
          s2_idx    = IDX_W'(k);
          if (k < int'(yng)) begin
            s1_found = 1'b1;
            s1_idx   = IDX_W'(k);
          end
        end
      end
    end

    assign sel_hit = any_found;
    assign sel_idx = s1_found ? s1_idx : s2_idx;

    assign req_ready[p] = !valid_q || resp_ready[p];
    assign accept       = req_valid[p] && req_ready[p];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        valid_q <= 1'b0;
        hit_q   <= 1'b0;
        idx_q   <= '0;
        multi_q <= 1'b0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
        hit_q   <= sel_hit;
        idx_q   <= sel_idx;
        multi_q <= many;
      end else if (resp_ready[p]) begin
        valid_q <= 1'b0;
      end
    end

    assign resp_valid[p]               = valid_q;
    assign resp_hit[p]                 = hit_q;
    assign resp_idx[p*IDX_W +: IDX_W]  = idx_q;
    assign resp_multi[p]               = multi_q;

    y_range_a: assert property (@(posedge clock) disable iff (!reset)
      req_valid[p] |-> ({1'b0, yng} < NUM_STQ_L));
  end

endmodule

// File: tb/tb_stq_fwd_age_select.sv
// Self-checking bench for stq_fwd_age_select (NUM_STQ=32, NUM_PORTS=2); honours STQ_HEAD_MASK_EN.
module tb_stq_fwd_age_select;
  localparam int N  = 32;
  localparam int W  = 5;
  localparam int NP = 2;

  logic            clock;
  logic            reset;
  logic            flush;
  logic [W-1:0]    stq_head;
  logic [NP-1:0]   req_valid;
  logic [NP-1:0]   req_ready;
  logic [NP*N-1:0] req_matches;
  logic [NP*W-1:0] req_youngest;
  logic [NP-1:0]   resp_valid;
  logic [NP-1:0]   resp_ready;
  logic [NP-1:0]   resp_hit;
  logic [NP*W-1:0] resp_idx;
  logic [NP-1:0]   resp_multi;

  stq_fwd_age_select #(.NUM_STQ(N), .NUM_PORTS(NP)) dut (
    .clock(clock), .reset(reset), .flush(flush), .stq_head(stq_head),
    .req_valid(req_valid), .req_ready(req_ready), .req_matches(req_matches),
    .req_youngest(req_youngest), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hit(resp_hit), .resp_idx(resp_idx), .resp_multi(resp_multi)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int p, input logic [31:0] m, input int y);
    req_matches[p*N +: N]  = m;
    req_youngest[p*W +: W] = W'(y);
  endtask

  function automatic logic [31:0] idx_of(input int p);
    return 32'(resp_idx[p*W +: W]);
  endfunction

  // Reference: walk backwards from y-1 with wrap; window is distance from head less than y-head (mod N)
  task automatic model(input logic [31:0] m, input int y, input int head,
                       output logic hit, output int idx, output logic multi);
    logic [31:0] mm;
    mm = m;
`ifdef STQ_HEAD_MASK_EN
    for (int k = 0; k < N; k++)
      if (((k - head + N) % N) >= ((y - head + N) % N)) mm[k] = 1'b0;
`else
    if (head < 0) mm = 0;
`endif
    hit   = 1'b0;
    idx   = 0;
    multi = ($countones(mm) > 1);
    for (int d = 1; d <= N; d++) begin
      int k;
      k = (y - d + 2*N) % N;
      if (!hit && mm[k]) begin
        hit = 1'b1;
        idx = k;
      end
    end
  endtask

  typedef struct {
    int          port;
    logic [31:0] m;
    int          y;
    int          head;
    logic        hit;
    int          idx;
    logic        multi;
  } vec_t;

  localparam int NV = 10;
  vec_t vec[NV];

  logic        e_hit[NP];
  int          e_idx[NP];
  logic        e_multi[NP];
  logic [31:0] rm;
  int          ry;
  int          rh;

  initial begin
`ifdef STQ_HEAD_MASK_EN
    vec[0] = '{0, 32'h0010_0008, 10, 25, 1'b1, 3,  1'b0};
    vec[1] = '{1, 32'h0000_0000, 10, 25, 1'b0, 0,  1'b0};
    vec[2] = '{0, 32'h0010_0008,  2,  4, 1'b1, 20, 1'b0};
    vec[3] = '{0, 32'h8000_0000,  0,  1, 1'b1, 31, 1'b0};
    vec[4] = '{0, 32'h0000_0001,  1,  0, 1'b1, 0,  1'b0};
    vec[5] = '{0, 32'h0010_0008, 10,  5, 1'b0, 0,  1'b0};
    vec[6] = '{1, 32'h4000_0004,  4, 28, 1'b1, 2,  1'b1};
    vec[7] = '{0, 32'hFFFF_FFFF, 12, 12, 1'b0, 0,  1'b0};
    vec[8] = '{1, 32'h0000_00E0,  6,  0, 1'b1, 5,  1'b0};
    vec[9] = '{1, 32'h0000_0001,  0,  0, 1'b0, 0,  1'b0};
`else
    vec[0] = '{0, 32'h0010_0008, 10, 25, 1'b1, 3,  1'b1};
    vec[1] = '{1, 32'h0000_0000, 10, 25, 1'b0, 0,  1'b0};
    vec[2] = '{0, 32'h0010_0008,  2,  4, 1'b1, 20, 1'b1};
    vec[3] = '{0, 32'h8000_0000,  0,  1, 1'b1, 31, 1'b0};
    vec[4] = '{0, 32'h0000_0001,  1,  0, 1'b1, 0,  1'b0};
    vec[5] = '{0, 32'h0010_0008, 10,  5, 1'b1, 3,  1'b1};
    vec[6] = '{1, 32'h4000_0004,  4, 28, 1'b1, 2,  1'b1};
    vec[7] = '{0, 32'hFFFF_FFFF, 12, 12, 1'b1, 11, 1'b1};
    vec[8] = '{1, 32'h0000_00E0,  6,  0, 1'b1, 5,  1'b1};
    vec[9] = '{1, 32'h0000_0001,  0,  0, 1'b1, 0,  1'b0};
`endif

    reset = 1'b0; flush = 1'b0; stq_head = '0; req_valid = '0;
    req_matches = '0; req_youngest = '0; resp_ready = 2'b11;
    #3;
    check("rst_valid", 32'(resp_valid), 32'h0);
    check("rst_hit",   32'(resp_hit),   32'h0);
    check("rst_idx",   32'(resp_idx),   32'h0);
    check("rst_multi", 32'(resp_multi), 32'h0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    #1 check("rst_ready", 32'(req_ready), 32'h3);

    // Directed table, one request at a time
    for (int i = 0; i < NV; i++) begin
      stq_head = W'(vec[i].head);
      set_req(vec[i].port, vec[i].m, vec[i].y);
      req_valid = '0;
      req_valid[vec[i].port] = 1'b1;
      @(posedge clock); #1;
      req_valid = '0;
      check($sformatf("vec%0d_valid", i), 32'(resp_valid[vec[i].port]), 32'h1);
      check($sformatf("vec%0d_hit", i),   32'(resp_hit[vec[i].port]),   32'(vec[i].hit));
      check($sformatf("vec%0d_idx", i),   idx_of(vec[i].port),          32'(vec[i].idx));
      check($sformatf("vec%0d_multi", i), 32'(resp_multi[vec[i].port]), 32'(vec[i].multi));
      @(posedge clock); #1;
      check($sformatf("vec%0d_drain", i), 32'(resp_valid), 32'h0);
    end

    // Backpressure on port 0
    stq_head = '0;
    resp_ready = 2'b10;
    set_req(0, 32'h0000_0080, 8);
    req_valid = 2'b01;
    @(posedge clock); #1;
    check("bp_first_idx", idx_of(0), 32'd7);
    set_req(0, 32'h0000_0020, 9);
    for (int c = 0; c < 4; c++) begin
      check("bp_ready_low", 32'(req_ready[0]), 32'h0);
      @(posedge clock); #1;
      check("bp_hold_idx",   idx_of(0), 32'd7);
      check("bp_hold_valid", 32'(resp_valid[0]), 32'h1);
    end
    resp_ready = 2'b11;
    #1 check("bp_ready_rise", 32'(req_ready[0]), 32'h1);
    @(posedge clock); #1;
    req_valid = '0;
    check("bp_new_idx",   idx_of(0), 32'd5);
    check("bp_new_valid", 32'(resp_valid[0]), 32'h1);
    @(posedge clock); #1;
    check("bp_drained", 32'(resp_valid), 32'h0);

    // Flush while port 0 holds and port 1 accepts
    resp_ready = 2'b10;
    set_req(0, 32'h0000_0200, 12);
    req_valid = 2'b01;
    @(posedge clock); #1;
    check("fl_hold", 32'(resp_valid), 32'h1);
    req_valid = 2'b10;
    set_req(1, 32'h0000_0010, 6);
    flush = 1'b1;
    #1 check("fl_ready", 32'(req_ready[1]), 32'h1);
    @(posedge clock); #1;
    flush = 1'b0;
    req_valid = '0;
    check("fl_cleared", 32'(resp_valid), 32'h0);
    resp_ready = 2'b11;

    // Back-to-back random traffic on both ports
    req_valid = 2'b11;
    rh = int'($urandom_range(0, N-1));
    stq_head = W'(rh);
    for (int p = 0; p < NP; p++) begin
      rm = $urandom;
      ry = int'($urandom_range(0, N-1));
      set_req(p, rm, ry);
      model(rm, ry, rh, e_hit[p], e_idx[p], e_multi[p]);
    end
    for (int c = 0; c < 40; c++) begin
      check("b2b_ready", 32'(req_ready), 32'h3);
      @(posedge clock); #1;
      for (int p = 0; p < NP; p++) begin
        check($sformatf("b2b_valid_p%0d", p), 32'(resp_valid[p]), 32'h1);
        check($sformatf("b2b_hit_p%0d", p),   32'(resp_hit[p]),   32'(e_hit[p]));
        check($sformatf("b2b_idx_p%0d", p),   idx_of(p),          32'(e_idx[p]));
        check($sformatf("b2b_multi_p%0d", p), 32'(resp_multi[p]), 32'(e_multi[p]));
      end
      rh = int'($urandom_range(0, N-1));
      stq_head = W'(rh);
      for (int p = 0; p < NP; p++) begin
        rm = $urandom;
        if ($urandom_range(0, 1) == 1) rm = rm & $urandom & $urandom;
        if ($urandom_range(0, 7) == 0) rm = '0;
        ry = int'($urandom_range(0, N-1));
        set_req(p, rm, ry);
        model(rm, ry, rh, e_hit[p], e_idx[p], e_multi[p]);
      end
    end
    req_valid = '0;
    @(posedge clock); #1;
    check("b2b_drained", 32'(resp_valid), 32'h0);

    // Asynchronous reset mid-stream
    resp_ready = 2'b00;
    stq_head = 5'd0;
    set_req(0, 32'h0000_0F00, 20);
    set_req(1, 32'h0000_0C00, 20);
    req_valid = 2'b11;
    @(posedge clock); #1;
    req_valid = '0;
    check("ar_pre_valid", 32'(resp_valid), 32'h3);
    #2 reset = 1'b0;
    #1;
    check("ar_valid", 32'(resp_valid), 32'h0);
    check("ar_hit",   32'(resp_hit),   32'h0);
    check("ar_idx",   32'(resp_idx),   32'h0);
    check("ar_multi", 32'(resp_multi), 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    resp_ready = 2'b11;
    @(posedge clock); #1;
    check("ar_no_resp", 32'(resp_valid), 32'h0);
    check("ar_ready",   32'(req_ready),  32'h3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
